// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - fetch/loader arbiter in front of a single-ported instruction memory
//
// Shares one synchronous-read IM array between the CPU fetch stage (reads)
// and the program loader (writes). Byte addresses are mapped to word indices
// relative to BASE_ADDR; misaligned or out-of-range accesses never reach memory.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   f_req, f_addr               fetch read request and byte address
//   f_gnt                       fetch accepted this cycle (combinational)
//   f_rvalid, f_rdata, f_err    fetch response, one cycle after f_gnt
//   l_req, l_addr, l_wdata      loader write request, byte address, data
//   l_gnt                       loader accepted this cycle (combinational)
//   l_err                       pulse one cycle after a rejected loader grant
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata        IM array port (read data one cycle after mem_en & !mem_we)
//   busy_cnt                    saturating count of cycles with both requests high

module im_port_arbiter #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int          DEPTH      = 4096,
   parameter int          IDX_W      = 12,
   parameter int          STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             f_req,
   input  logic [31:0]      f_addr,
   output logic             f_gnt,
   output logic             f_rvalid,
   output logic [31:0]      f_rdata,
   output logic             f_err,
   input  logic             l_req,
   input  logic [31:0]      l_addr,
   input  logic [31:0]      l_wdata,
   output logic             l_gnt,
   output logic             l_err,
   output logic             mem_en,
   output logic             mem_we,
   output logic [IDX_W-1:0] mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [15:0]      busy_cnt
);

   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [31:0]     DEPTH_W    = 32'(DEPTH);

   // The lower-bound test guards the subtraction: an address below BASE_ADDR
   // wraps to a huge offset, which must not alias back into the array.
   function automatic logic addr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ((off >> 2) < DEPTH_W);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   logic          f_ok, l_ok, contested;
   logic [SW-1:0] starve_q, starve_d;
   logic [15:0]   busy_q, busy_d;
   logic          f_rvalid_q, f_rvalid_d;
   logic          f_err_q, f_err_d;
   logic          l_err_q, l_err_d;

   assign f_ok      = addr_ok(f_addr);
   assign l_ok      = addr_ok(l_addr);
   assign contested = f_req && l_req;

   always_comb begin
      f_gnt      = 1'b0;
      l_gnt      = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      starve_d   = starve_q;
      busy_d     = busy_q;
      f_rvalid_d = 1'b0;
      f_err_d    = 1'b0;
      l_err_d    = 1'b0;
      if (reset) begin
         // Fetch wins every contest until the loader has lost STARVE_MAX in a row.
         if (l_req && (!f_req || starve_q == STARVE_LIM)) begin
            l_gnt = 1'b1;
         end else if (f_req) begin
            f_gnt = 1'b1;
         end

         if (f_gnt) begin
            mem_en     = f_ok;
            mem_addr   = f_ok ? addr_idx(f_addr) : '0;
            f_rvalid_d = 1'b1;
            f_err_d    = !f_ok;
         end else if (l_gnt) begin
            mem_en    = l_ok;
            mem_we    = l_ok;
            mem_addr  = l_ok ? addr_idx(l_addr) : '0;
            mem_wdata = l_ok ? l_wdata : '0;
            l_err_d   = !l_ok;
         end

         if (l_gnt) begin
            starve_d = '0;
         end else if (contested) begin
            starve_d = starve_q + 1'b1;
         end

         if (contested && busy_q != 16'hFFFF) begin
            busy_d = busy_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_q   <= '0;
         busy_q     <= '0;
         f_rvalid_q <= 1'b0;
         f_err_q    <= 1'b0;
         l_err_q    <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         busy_q     <= busy_d;
         f_rvalid_q <= f_rvalid_d;
         f_err_q    <= f_err_d;
         l_err_q    <= l_err_d;
      end
   end

   // Gating with reset drops a response whose grant was just before reset fell.
   assign f_rvalid = f_rvalid_q && reset;
   assign f_err    = f_err_q && reset;
   assign l_err    = l_err_q && reset;
   assign f_rdata  = (f_rvalid && !f_err) ? mem_rdata : 32'h0;
   assign busy_cnt = busy_q;

endmodule
